sample_mac_pipe: RTL and testbench

Parametrised pipelined multiply / multiply-accumulate unit for the HLS-generated datapath. Multiplies an unsigned operand by a signed operand over a configurable number of pipeline stages. Each beat either returns the scaled, saturated product directly or accumulates it into a running dot product that is emitted on the beat flagged last. It is the successor to the fixed 8×14 single-register multiplier and adds valid tracking, accumulate mode, scaling and saturation.

---
 rtl/sample_mac_pipe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sample_mac_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_mac_pipe.sv
// Pipelined unsigned x signed multiplier with an optional saturating dot-product
// accumulator, arithmetic output scaling and output clipping.
module sample_mac_pipe #(
   parameter int A_WIDTH    = 8,
   parameter int B_WIDTH    = 14,
   parameter int P_WIDTH    = 14,
   parameter int ACC_WIDTH  = 24,
   parameter int NUM_STAGE  = 3,
   parameter int FRAC_SHIFT = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ce,
   input  logic               in_valid,
   input  logic [A_WIDTH-1:0] din0,
   input  logic [B_WIDTH-1:0] din1,
   input  logic               acc_mode,
   input  logic               in_last,
   output logic               out_valid,
   output logic [P_WIDTH-1:0] dout,
   output logic               sat
);

   localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;
   localparam int PIPE_DEPTH = NUM_STAGE - 1;

   typedef enum logic {
      ST_IDLE,
      ST_ACCUM
   } accState_t;

   // Returns {clip, value}: value >>> FRAC_SHIFT clipped into the signed P_WIDTH range.
   function automatic logic [P_WIDTH:0] scaleSat(input logic signed [ACC_WIDTH-1:0] value);
      logic signed [ACC_WIDTH-1:0] shifted;
      logic [ACC_WIDTH-P_WIDTH:0]  upper;
      shifted = value >>> FRAC_SHIFT;
      upper   = shifted[ACC_WIDTH-1:P_WIDTH-1];
      if ((&upper) || !(|upper))
         scaleSat = {1'b0, shifted[P_WIDTH-1:0]};
      else if (shifted[ACC_WIDTH-1])
         scaleSat = {1'b1, 1'b1, {(P_WIDTH-1){1'b0}}};
      else
         scaleSat = {1'b1, 1'b0, {(P_WIDTH-1){1'b1}}};
   endfunction

   logic [A_WIDTH-1:0] r_s1A;
   logic [B_WIDTH-1:0] r_s1B;
   logic               r_s1Valid;
   logic               r_s1Acc;
   logic               r_s1Last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1A     <= '0;
         r_s1B     <= '0;
         r_s1Valid <= 1'b0;
         r_s1Acc   <= 1'b0;
         r_s1Last  <= 1'b0;
      end else if (ce) begin
         r_s1A     <= din0;
         r_s1B     <= din1;
         r_s1Valid <= in_valid;
         r_s1Acc   <= acc_mode;
         r_s1Last  <= in_last;
      end
   end

   // din0 is zero-extended (unsigned), din1 sign-extended; the full-width product is exact.
   logic signed [PROD_WIDTH-1:0] w_aExt;
   logic signed [PROD_WIDTH-1:0] w_bExt;
   logic signed [PROD_WIDTH-1:0] w_product;

   assign w_aExt    = {{B_WIDTH{1'b0}}, r_s1A};
   assign w_bExt    = {{A_WIDTH{r_s1B[B_WIDTH-1]}}, r_s1B};
   assign w_product = w_aExt * w_bExt;

   logic signed [PROD_WIDTH-1:0] r_prod [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0]        r_pValid;
   logic [PIPE_DEPTH-1:0]        r_pAcc;
   logic [PIPE_DEPTH-1:0]        r_pLast;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_prod[i] <= '0;
         end
         r_pValid <= '0;
         r_pAcc   <= '0;
         r_pLast  <= '0;
      end else if (ce) begin
         r_prod[0]   <= w_product;
         r_pValid[0] <= r_s1Valid;
         r_pAcc[0]   <= r_s1Acc;
         r_pLast[0]  <= r_s1Last;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_prod[i]   <= r_prod[i-1];
            r_pValid[i] <= r_pValid[i-1];
            r_pAcc[i]   <= r_pAcc[i-1];
            r_pLast[i]  <= r_pLast[i-1];
         end
      end
   end

   logic signed [ACC_WIDTH-1:0] w_tailProd;
   logic                        w_tailMulValid;
   logic                        w_tailAccValid;
   logic                        w_tailLast;

   assign w_tailProd     = ACC_WIDTH'(r_prod[PIPE_DEPTH-1]);
   assign w_tailMulValid = r_pValid[PIPE_DEPTH-1] & ~r_pAcc[PIPE_DEPTH-1];
   assign w_tailAccValid = r_pValid[PIPE_DEPTH-1] &  r_pAcc[PIPE_DEPTH-1];
   assign w_tailLast     = r_pLast[PIPE_DEPTH-1];

   accState_t                   r_state;
   accState_t                   w_stateNext;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [ACC_WIDTH-1:0] w_accNext;
   logic                        r_sticky;
   logic                        w_stickyNext;
   logic signed [ACC_WIDTH:0]   w_sum;
   logic signed [ACC_WIDTH-1:0] w_accSum;
   logic                        w_addClip;

   assign w_sum = {r_acc[ACC_WIDTH-1], r_acc} + {w_tailProd[ACC_WIDTH-1], w_tailProd};

   always_comb begin
      w_addClip = 1'b0;
      w_accSum  = w_sum[ACC_WIDTH-1:0];
      if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
         w_addClip = 1'b1;
         w_accSum  = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_sticky <= 1'b0;
      end else if (ce) begin
         r_state  <= w_stateNext;
         r_acc    <= w_accNext;
         r_sticky <= w_stickyNext;
      end
   end

   // Multiply beats pass the accumulator untouched; only accumulate beats move the FSM.
   always_comb begin
      w_stateNext  = r_state;
      w_accNext    = r_acc;
      w_stickyNext = r_sticky;
      if (w_tailAccValid) begin
         case (r_state)
            ST_IDLE: begin
               w_accNext    = w_tailProd;
               w_stickyNext = 1'b0;
            end
            ST_ACCUM: begin
               w_accNext    = w_accSum;
               w_stickyNext = r_sticky | w_addClip;
            end
         endcase
         w_stateNext = w_tailLast ? ST_IDLE : ST_ACCUM;
      end
   end

   logic [P_WIDTH:0]   w_accRes;
   logic [P_WIDTH:0]   w_mulRes;
   logic               r_aoValid;
   logic [P_WIDTH-1:0] r_aoDout;
   logic               r_aoSat;

   assign w_accRes = scaleSat(w_accNext);
   assign w_mulRes = scaleSat(w_tailProd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aoValid <= 1'b0;
         r_aoDout  <= '0;
         r_aoSat   <= 1'b0;
      end else if (ce) begin
         r_aoValid <= w_tailAccValid & w_tailLast;
         r_aoDout  <= w_accRes[P_WIDTH-1:0];
         r_aoSat   <= w_accRes[P_WIDTH] | w_stickyNext;
      end
   end

   // A vector result is one stage later than a multiply result, so a multiply issued right
   // after a last term collides with it; the one-entry skid keeps results in issue order.
   logic               r_outValid;
   logic [P_WIDTH-1:0] r_dout;
   logic               r_sat;
   logic               r_skidValid;
   logic [P_WIDTH-1:0] r_skidDout;
   logic               r_skidSat;
   logic               w_outValid;
   logic [P_WIDTH-1:0] w_outDout;
   logic               w_outSat;
   logic               w_skidValid;
   logic [P_WIDTH-1:0] w_skidDout;
   logic               w_skidSat;

   always_comb begin
      w_outValid  = 1'b0;
      w_outDout   = r_dout;
      w_outSat    = r_sat;
      w_skidValid = 1'b0;
      w_skidDout  = r_skidDout;
      w_skidSat   = r_skidSat;
      if (r_skidValid) begin
         w_outValid = 1'b1;
         w_outDout  = r_skidDout;
         w_outSat   = r_skidSat;
         if (r_aoValid) begin
            w_skidValid = 1'b1;
            w_skidDout  = r_aoDout;
            w_skidSat   = r_aoSat;
         end else if (w_tailMulValid) begin
            w_skidValid = 1'b1;
            w_skidDout  = w_mulRes[P_WIDTH-1:0];
            w_skidSat   = w_mulRes[P_WIDTH];
         end
      end else if (r_aoValid) begin
         w_outValid = 1'b1;
         w_outDout  = r_aoDout;
         w_outSat   = r_aoSat;
         if (w_tailMulValid) begin
            w_skidValid = 1'b1;
            w_skidDout  = w_mulRes[P_WIDTH-1:0];
            w_skidSat   = w_mulRes[P_WIDTH];
         end
      end else if (w_tailMulValid) begin
         w_outValid = 1'b1;
         w_outDout  = w_mulRes[P_WIDTH-1:0];
         w_outSat   = w_mulRes[P_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_outValid  <= 1'b0;
         r_dout      <= '0;
         r_sat       <= 1'b0;
         r_skidValid <= 1'b0;
         r_skidDout  <= '0;
         r_skidSat   <= 1'b0;
      end else if (ce) begin
         r_outValid  <= w_outValid;
         r_dout      <= w_outDout;
         r_sat       <= w_outSat;
         r_skidValid <= w_skidValid;
         r_skidDout  <= w_skidDout;
         r_skidSat   <= w_skidSat;
      end
   end

   assign out_valid = r_outValid;
   assign dout      = r_dout;
   assign sat       = r_sat;

endmodule

// File: tb/tb_sample_mac_pipe.sv
// Self-checking bench for sample_mac_pipe: directed and random beats compared against
// an arithmetic reference model that predicts in-order results per ce-cycle.
module tb_sample_mac_pipe;

   localparam int A_WIDTH    = 8;
   localparam int B_WIDTH    = 14;
   localparam int P_WIDTH    = 14;
   localparam int ACC_WIDTH  = 24;
   localparam int NUM_STAGE  = 3;
   localparam int FRAC_SHIFT = 0;

   logic               clk = 1'b0;
   logic               reset;
   logic               ce;
   logic               in_valid;
   logic [A_WIDTH-1:0] din0;
   logic [B_WIDTH-1:0] din1;
   logic               acc_mode;
   logic               in_last;
   logic               out_valid;
   logic [P_WIDTH-1:0] dout;
   logic               sat;

   always #5 clk = ~clk;

   sample_mac_pipe #(
      .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH),
      .ACC_WIDTH(ACC_WIDTH), .NUM_STAGE(NUM_STAGE), .FRAC_SHIFT(FRAC_SHIFT)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(din0), .din1(din1), .acc_mode(acc_mode), .in_last(in_last),
      .out_valid(out_valid), .dout(dout), .sat(sat)
   );

   typedef struct {
      longint dueCycle;
      longint value;
      bit     satFlag;
   } expEntry_t;

   expEntry_t expQueue[$];
   int        total = 0;
   int        bad   = 0;
   longint    ceCycle = 0;
   longint    lastOutCycle = 0;
   longint    accModel = 0;
   bit        stickyModel = 1'b0;
   bit        inVector = 1'b0;
   logic      expValid = 1'b0;
   longint    expDout = 0;
   logic      expSat = 1'b0;

   // Clip v into the signed w-bit range, flagging whether clipping happened.
   function automatic longint satRange(input longint v, input int w, output bit clip);
      longint hi;
      longint lo;
      hi   = (longint'(1) << (w - 1)) - 1;
      lo   = -(longint'(1) << (w - 1));
      clip = 1'b0;
      if (v > hi) begin
         clip = 1'b1;
         return hi;
      end
      if (v < lo) begin
         clip = 1'b1;
         return lo;
      end
      return v;
   endfunction

   // Results leave strictly in issue order, at most one per ce-cycle, never before due.
   task automatic pushResult(input longint due, input longint raw, input bit stickyIn);
      expEntry_t e;
      bit        clip;
      e.value    = satRange(raw >>> FRAC_SHIFT, P_WIDTH, clip);
      e.satFlag  = clip | stickyIn;
      e.dueCycle = (due > lastOutCycle) ? due : lastOutCycle + 1;
      lastOutCycle = e.dueCycle;
      expQueue.push_back(e);
   endtask

   task automatic modelAccept(input int a, input int b, input bit acc, input bit last);
      longint p;
      longint s;
      bit     clip;
      p = longint'(a) * longint'(b);
      if (!acc) begin
         pushResult(ceCycle + NUM_STAGE, p, 1'b0);
      end else begin
         if (!inVector) begin
            accModel    = p;
            stickyModel = 1'b0;
         end else begin
            s           = satRange(accModel + p, ACC_WIDTH, clip);
            accModel    = s;
            stickyModel = stickyModel | clip;
         end
         if (last) begin
            pushResult(ceCycle + NUM_STAGE + 1, accModel, stickyModel);
            inVector = 1'b0;
         end else begin
            inVector = 1'b1;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [P_WIDTH-1:0] expBits;
      total++;
      assert (out_valid === expValid) else begin
         bad++;
         $error("[TB] FAIL %s out_valid @cecycle %0d: observed=%0b expected=%0b",
                tag, ceCycle, out_valid, expValid);
      end
      if (expValid) begin
         expBits = P_WIDTH'(expDout);
         total++;
         assert (dout === expBits) else begin
            bad++;
            $error("[TB] FAIL %s dout @cecycle %0d: observed=%0d expected=%0d",
                   tag, ceCycle, $signed(dout), expDout);
         end
         total++;
         assert (sat === expSat) else begin
            bad++;
            $error("[TB] FAIL %s sat @cecycle %0d: observed=%0b expected=%0b",
                   tag, ceCycle, sat, expSat);
         end
      end
   endtask

   task automatic checkReset(input string tag);
      total++;
      assert (out_valid === 1'b0 && dout === '0 && sat === 1'b0) else begin
         bad++;
         $error("[TB] FAIL %s reset outputs: observed valid=%0b dout=%0d sat=%0b expected 0/0/0",
                tag, out_valid, $signed(dout), sat);
      end
   endtask

   task automatic applyStimulus(input bit ceV, input bit v, input int a, input int b,
                                input bit acc, input bit last, input string tag);
      ce       = ceV;
      in_valid = v;
      din0     = A_WIDTH'(a);
      din1     = B_WIDTH'(b);
      acc_mode = acc;
      in_last  = last;
      @(posedge clk);
      if (ceV) begin
         ceCycle++;
         if (v) modelAccept(a, b, acc, last);
         expValid = 1'b0;
         if (expQueue.size() > 0 && expQueue[0].dueCycle == ceCycle) begin
            expValid = 1'b1;
            expDout  = expQueue[0].value;
            expSat   = expQueue[0].satFlag;
            void'(expQueue.pop_front());
         end
      end
      #1;
      checkOutput(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, tag);
   endtask

   task automatic doReset(input int edges);
      ce       = 1'b1;
      in_valid = 1'b1;
      din0     = A_WIDTH'(77);
      din1     = B_WIDTH'(99);
      acc_mode = 1'b1;
      in_last  = 1'b0;
      reset    = 1'b1;
      #1;
      checkReset("async_reset");
      for (int i = 0; i < edges; i++) begin
         @(posedge clk);
         #1;
         checkReset("held_reset");
      end
      reset = 1'b0;
      expQueue.delete();
      inVector     = 1'b0;
      expValid     = 1'b0;
      lastOutCycle = ceCycle;
   endtask

   initial begin
      bit ceR;
      bit vR;
      bit accR;
      bit lastR;
      int aR;
      int bR;

      ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; acc_mode = 1'b0; in_last = 1'b0;
      reset = 1'b1;
      doReset(2);

      $display("[TB] multiply 200 x -5");
      applyStimulus(1'b1, 1'b1, 200, -5, 1'b0, 1'b0, "mul_basic");
      idle(5, "mul_basic");

      $display("[TB] multiply saturation");
      applyStimulus(1'b1, 1'b1, 255, 8191, 1'b0, 1'b0, "mul_sat_pos");
      applyStimulus(1'b1, 1'b1, 255, -8192, 1'b0, 1'b0, "mul_sat_neg");
      idle(5, "mul_sat");

      $display("[TB] four-term dot product");
      applyStimulus(1'b1, 1'b1, 10, 3, 1'b1, 1'b0, "acc4");
      applyStimulus(1'b1, 1'b1, 20, -4, 1'b1, 1'b0, "acc4");
      applyStimulus(1'b1, 1'b1, 1, 100, 1'b1, 1'b0, "acc4");
      applyStimulus(1'b1, 1'b1, 0, -7, 1'b1, 1'b1, "acc4");
      idle(6, "acc4");

      $display("[TB] back-to-back vectors");
      applyStimulus(1'b1, 1'b1, 2, 3, 1'b1, 1'b1, "b2b");
      applyStimulus(1'b1, 1'b1, 4, 5, 1'b1, 1'b0, "b2b");
      applyStimulus(1'b1, 1'b1, 1, 1, 1'b1, 1'b1, "b2b");
      idle(6, "b2b");

      $display("[TB] stall in a multiply stream");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b1, 13 * i + 7, 100 * i - 150, 1'b0, 1'b0, "stall");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b1, 99, 99, 1'b0, 1'b0, "stall_hold");
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, 1'b1, 31 + i, -1000 + i, 1'b0, 1'b0, "stall");
      idle(6, "stall");

      $display("[TB] reset mid-vector");
      applyStimulus(1'b1, 1'b1, 50, 50, 1'b1, 1'b0, "rst_mid");
      applyStimulus(1'b1, 1'b1, 50, 50, 1'b1, 1'b0, "rst_mid");
      doReset(1);
      applyStimulus(1'b1, 1'b1, 2, 3, 1'b1, 1'b1, "rst_mid");
      idle(6, "rst_mid");

      $display("[TB] multiply right behind a last term");
      applyStimulus(1'b1, 1'b1, 3, 4, 1'b1, 1'b1, "order");
      applyStimulus(1'b1, 1'b1, 5, 6, 1'b0, 1'b0, "order");
      applyStimulus(1'b1, 1'b1, 7, 8, 1'b0, 1'b0, "order");
      idle(6, "order");

      $display("[TB] accumulator saturation");
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 1'b1, 255, 8191, 1'b1, (i == 5), "acc_sat_pos");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b1, 255, -8192, 1'b1, (i == 4), "acc_sat_neg");
      idle(6, "acc_sat");

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         ceR   = ($urandom_range(0, 99) < 85);
         vR    = ($urandom_range(0, 99) < 75);
         accR  = ($urandom_range(0, 99) < 60);
         lastR = ($urandom_range(0, 5) == 0);
         aR    = int'($urandom_range(0, 255));
         bR    = int'($urandom_range(0, 16383)) - 8192;
         applyStimulus(ceR, vR, aR, bR, accR, lastR, "random");
      end
      applyStimulus(1'b1, 1'b1, 1, 1, 1'b1, 1'b1, "random_close");
      idle(20, "drain");

      total++;
      assert (expQueue.size() === 0) else begin
         bad++;
         $error("[TB] FAIL drain pending results: observed=%0d expected=0", expQueue.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
